// File: rtl/sr_pkg.sv
// Shared constants and state encoding for the word-serial split/merge pair.
package sr_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 9;
  localparam int unsigned OUT_W   = WORD_W * N_WORDS;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/merging.sv
// Serial-to-parallel packer: collects N_WORDS words MSB-first into one wide
// vector and holds it until the downstream consumes it.
module merging
  import sr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_cnt
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               valid_n;
  logic [CNT_W-1:0]   wr_slot;
  logic               accept;
  logic [N_WORDS-1:0] slot_we;

  // In FULL the next vector may start in the same edge the current one leaves.
  assign in_ready = (state == ST_FILL) || out_ready;

  always_comb begin
    state_n = state;
    cnt_n   = word_cnt;
    valid_n = out_valid;
    wr_slot = word_cnt;
    accept  = in_valid && in_ready;
    case (state)
      ST_FILL: begin
        if (accept) begin
          if (word_cnt == CNT_W'(N_WORDS - 1)) begin
            state_n = ST_FULL;
            cnt_n   = '0;
            valid_n = 1'b1;
          end else begin
            cnt_n = word_cnt + CNT_W'(1);
          end
        end
      end
      ST_FULL: begin
        wr_slot = '0;
        if (out_ready) begin
          state_n = ST_FILL;
          valid_n = 1'b0;
          cnt_n   = in_valid ? CNT_W'(1) : CNT_W'(0);
        end
      end
      default: begin
        state_n = ST_FILL;
        cnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FILL;
      word_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      word_cnt  <= cnt_n;
      out_valid <= valid_n;
    end
  end

  // One write enable per slot; slot 0 occupies the top word of out_data.
  for (genvar i = 0; i < N_WORDS; i++) begin : g_slot_we
    assign slot_we[i] = accept && (wr_slot == CNT_W'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
    end else begin
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        if (slot_we[i]) out_data[OUT_W-1-i*WORD_W -: WORD_W] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_merging.sv
// Directed bench for merging with a vector scoreboard on the output handshake.
module tb_merging;
  import sr_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  word_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [OUT_W-1:0] sb_q[$];
  logic [OUT_W-1:0] exp_vec;
  logic [OUT_W-1:0] sb_last;
  int exp_k       = 0;
  int n_pushed    = 0;
  int n_popped    = 0;
  int last_pop    = 0;
  int prev_pop    = 0;
  int acc_cyc     = 0;

  merging dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [OUT_W-1:0] got,
                     input logic [OUT_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every consumed vector.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_vector", out_data, '0);
        checks++;
        failures++;
        $error("FAIL sb_empty observed=vector expected=none");
      end else begin
        chk("vector", out_data, sb_q.pop_front());
      end
      n_popped++;
      prev_pop = last_pop;
      last_pop = cyc;
    end
  end

  task automatic push_word(input logic [WORD_W-1:0] w);
    int  n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    in_data  = 'x;
    if (!acc) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=%0d expected=<50", n);
    end else begin
      acc_cyc = cyc;
      exp_vec[OUT_W-1-exp_k*WORD_W -: WORD_W] = w;
      if (exp_k == int'(N_WORDS) - 1) begin
        sb_q.push_back(exp_vec);
        sb_last = exp_vec;
        n_pushed++;
        exp_k = 0;
      end else begin
        exp_k++;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", OUT_W'(sb_q.size()), '0);
  endtask

  initial begin
    int c0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    exp_vec   = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    chk("rst_word_cnt", OUT_W'(word_cnt), OUT_W'(0));
    chk("rst_out_data", out_data, '0);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    @(posedge clk);
    #1;

    // Basic fill with downstream always ready.
    for (int k = 0; k < 9; k++) push_word(32'h3f000000 + 32'(k) * 32'h00100000);
    chk("t1_out_valid", OUT_W'(out_valid), OUT_W'(1));
    chk("t1_word_cnt", OUT_W'(word_cnt), OUT_W'(0));
    chk("t1_literal", out_data,
        288'h3f0000003f1000003f2000003f3000003f4000003f5000003f6000003f7000003f800000);
    @(posedge clk);
    #1;
    chk("t1_consumed", OUT_W'(out_valid), OUT_W'(0));

    // Back-pressure: vector held, 10th word stalled then lands in slot 0.
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) push_word(32'h3f000000 + 32'(k) * 32'h00100000);
    chk("t2_out_valid", OUT_W'(out_valid), OUT_W'(1));
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_in_ready_low", OUT_W'(in_ready), OUT_W'(0));
      chk("t2_held_data", out_data, sb_last);
      @(posedge clk);
      #1;
    end
    chk("t2_cnt_held", OUT_W'(word_cnt), OUT_W'(0));
    out_ready = 1'b1;
    push_word(32'h40000000);
    chk("t2_cnt_one", OUT_W'(word_cnt), OUT_W'(1));
    chk("t2_valid_low", OUT_W'(out_valid), OUT_W'(0));
    chk("t2_slot0", OUT_W'(out_data[OUT_W-1 -: WORD_W]), OUT_W'(32'h40000000));
    for (int k = 1; k < 9; k++) push_word(32'h40000000 + 32'(k));
    drain();

    // Continuous 18-word stream: second vector exactly 9 cycles after first.
    for (int k = 0; k < 18; k++) push_word(32'h41000000 + 32'(k));
    drain();
    chk("t3_spacing", OUT_W'(last_pop - prev_pop), OUT_W'(9));

    // in_valid every other cycle: 9 accepts span 17 cycles.
    c0 = 0;
    for (int k = 0; k < 9; k++) begin
      push_word(32'h42000000 + 32'(k) * 32'h11);
      if (k == 0) c0 = acc_cyc;
      if (k != 8) begin
        @(posedge clk);
        #1;
      end
    end
    chk("t4_span", OUT_W'(acc_cyc - c0), OUT_W'(16));
    drain();

    // Reset mid-fill discards the partial vector.
    for (int k = 0; k < 4; k++) push_word(32'hdead0000 + 32'(k));
    reset = 1'b0;
    #2;
    chk("t5_word_cnt", OUT_W'(word_cnt), OUT_W'(0));
    chk("t5_out_valid", OUT_W'(out_valid), OUT_W'(0));
    chk("t5_out_data", out_data, '0);
    exp_k = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) push_word(32'h43000000 + 32'(k));
    drain();

    // Random vector.
    for (int k = 0; k < 9; k++) push_word($urandom);
    drain();

    chk("total_vectors", OUT_W'(n_popped), OUT_W'(n_pushed));
    chk("vector_count", OUT_W'(n_pushed), OUT_W'(8));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/merging.md
# merging

Serial-to-parallel packer, the receive-side counterpart of `splitting`. Accepts 32-bit IEEE-754 words one per handshake and assembles `N_WORDS` of them into one wide vector matching the `conv_out` layout consumed by the convolution datapath. Sits between a word-serial source (DMA/stream or `splitting` output) and any block expecting a full 3x3 window. Holds the assembled vector until the downstream accepts it, with back-pressure to the source.

## Interface
- `WORD_W`, 32, bits per word
- `N_WORDS`, 9, words per packed vector; `OUT_W = WORD_W*N_WORDS` (288)

- `clk` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-low reset
- `in_data` in WORD_W serial input word
- `in_valid` in 1 source has a word on `in_data`
- `in_ready` out 1 block can accept a word this cycle
- `out_data` out OUT_W packed vector
- `out_valid` out 1 `out_data` holds a complete vector
- `out_ready` in 1 downstream accepts vector this cycle
- `word_cnt` out 4 words captured into the vector being filled (0..N_WORDS-1)

## Operation
- Input handshake: word accepted on rising edge where `in_valid && in_ready`. Output handshake: vector consumed on edge where `out_valid && out_ready`.
- Word order: first accepted word → `out_data[OUT_W-1 -: WORD_W]` (bits 287:256); k-th word (k=0..8) → bits `[OUT_W-1-k*WORD_W -: WORD_W]`; last word → bits 31:0. Identical to the MSB-first order `splitting` emits.
- States:
  - FILL: `in_ready`=1, `out_valid`=0. Each accepted word is written to slot `word_cnt`, `word_cnt` increments. Accepting word with `word_cnt`=N_WORDS-1 → FULL, `word_cnt`←0.
  - FULL: `out_valid`=1, `out_data` stable. `in_ready` = `out_ready` (bypass).
    - `out_ready`=0: hold; incoming words not accepted; `out_data`, `word_cnt` unchanged.
    - `out_ready`=1, `in_valid`=0: vector consumed → FILL, `word_cnt`=0.
    - `out_ready`=1, `in_valid`=1: vector consumed and `in_data` written to slot 0 of next vector in same edge → FILL, `word_cnt`=1.
- Slots not yet rewritten in FILL retain old contents; `out_data` only meaningful while `out_valid`=1.
- `in_data` ignored when not accepted; no X propagation into registers.
- Reset (asserted any time, incl. mid-fill or FULL): state→FILL, `word_cnt`→0, `out_data`→0, `out_valid`→0; partially assembled vector discarded. `in_ready` reads 1 while in reset-released FILL.

## Timing
- All outputs registered except `in_ready` (combinational from state and `out_ready`).
- Latency: 9th word accepted at edge T → `out_valid`=1 and full `out_data` visible after edge T.
- Throughput: with `in_valid`, `out_ready` held high, one vector per 9 cycles, no bubble.
- `word_cnt` never reaches N_WORDS; wraps 8→0 on completion.
- Reset deassertion: first word may be accepted on first rising edge after `reset` goes high.

## Structure
- Shared package `sr_pkg`: `WORD_W`, `N_WORDS`, `OUT_W`, state encoding (`ST_FILL`, `ST_FULL`), same constants used by `splitting`.
- Single module; slot-write decode inline (generate loop over N_WORDS). No sub-module warranted.

## Test plan
- Stream 3f000000,3f100000,…,3f800000 with `out_ready`=1 → `out_valid` high one cycle after 9th word, `out_data`=288'h3f0000003f1000003f2000003f3000003f4000003f5000003f6000003f7000003f800000.
- Same 9 words, `out_ready`=0 for 5 cycles, 10th word 40000000 driven → `in_ready`=0, `out_data` unchanged, 40000000 not captured until `out_ready`=1, then becomes slot 0 with `word_cnt`=1.
- Continuous 18-word stream, `out_ready`=1 → two vectors, second `out_valid` exactly 9 cycles after first, no stall.
- `in_valid` toggled every other cycle → vector completes after 9 accepted words (17 cycles), contents in acceptance order.
- `reset` pulsed low after 4 words → `word_cnt`=0, `out_valid`=0, `out_data`=0; next 9 words form clean vector.
- Loopback `splitting`→`merging` with random 288-bit `conv_out` → `out_data` equals `conv_out`.
